// File: rtl/feedback_scheduler.sv
// Arbitrates the single LED/piezo feedback channel: queues one-shot success/fail
// events, plays them for SHOW_MS cycles with a GAP_MS idle gap, and lets level alarms pre-empt.
module feedback_scheduler #(
    parameter int SHOW_MS = 500,
    parameter int GAP_MS  = 100
) (
    input  logic       clk_1khz,
    input  logic       rst,
    input  logic       req_success,
    input  logic       req_fail,
    input  logic       emergency,
    input  logic       lockout,
    output logic [3:0] fb_state,
    output logic       busy,
    output logic [2:0] q_count,
    output logic       ovf,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] C_IDLE       = 4'b0000;
    localparam logic [3:0] C_SUCCESS    = 4'b0111;
    localparam logic [3:0] C_FAIL       = 4'b1000;
    localparam logic [3:0] C_DEACTIVATE = 4'b1001;
    localparam logic [3:0] C_EMERGENCY  = 4'b1010;
    localparam logic [9:0] SHOW_LOAD    = 10'(SHOW_MS - 1);
    localparam logic [9:0] GAP_LOAD     = 10'(GAP_MS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP, S_LEVEL} state_t;

    state_t     r_state;
    logic [9:0] r_timer;
    logic [3:0] r_fb;
    logic       r_ovf;
    logic       r_q [4];
    logic [1:0] r_wptr;
    logic [1:0] r_rptr;
    logic [2:0] r_count;

    logic w_level;
    logic w_req;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_head;

    // Requests are fire-and-forget pulses with no ready/backpressure: a request is
    // accepted on its sampling edge if there is room (or a pop frees a slot that
    // same edge); otherwise it is dropped and ovf pulses for the following cycle.
    assign w_level = emergency | lockout;
    assign w_req   = req_success | req_fail;
    assign w_full  = (r_count == 3'd4);
    assign w_pop   = (r_state == S_IDLE) && !w_level && (r_count != 3'd0);
    assign w_push  = w_req && (!w_full || w_pop);
    assign w_drop  = (req_success && req_fail) || (w_req && w_full && !w_pop);
    assign w_head  = r_q[r_rptr];

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_q[0]  <= 1'b0;
            r_q[1]  <= 1'b0;
            r_q[2]  <= 1'b0;
            r_q[3]  <= 1'b0;
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_q[r_wptr] <= req_fail;
                r_wptr      <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            r_count <= r_count + {2'd0, w_push} - {2'd0, w_pop};
            r_ovf   <= w_drop;
        end
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= 10'd0;
            r_fb    <= C_IDLE;
        end else if (w_level) begin
            // Alarms abort any one-shot in progress; the aborted event is not re-queued.
            r_state <= S_LEVEL;
            r_fb    <= emergency ? C_EMERGENCY : C_DEACTIVATE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_fb    <= w_head ? C_FAIL : C_SUCCESS;
                        r_timer <= SHOW_LOAD;
                        r_state <= S_SHOW;
                    end else begin
                        r_fb <= C_IDLE;
                    end
                end
                S_SHOW: begin
                    if (r_timer == 10'd0) begin
                        r_fb    <= C_IDLE;
                        r_timer <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_timer <= r_timer - 10'd1;
                    end
                end
                S_GAP: begin
                    r_fb <= C_IDLE;
                    if (r_timer == 10'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer - 10'd1;
                    end
                end
                S_LEVEL: begin
                    // Forced gap lets the controller re-arm before the next one-shot.
                    r_fb    <= C_IDLE;
                    r_timer <= GAP_LOAD;
                    r_state <= S_GAP;
                end
                default: begin
                    r_fb    <= C_IDLE;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fb_state  = r_fb;
    assign ovf       = r_ovf;
    assign q_count   = r_count;
    assign busy      = (r_state != S_IDLE) || (r_count != 3'd0);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_feedback_scheduler.sv
// Directed and random stimulus for feedback_scheduler, checked every cycle against
// a timeline model built from a bit queue and elapsed-cycle counters.
module tb_feedback_scheduler;

  localparam int SHOW = 6;
  localparam int GAP  = 3;

  localparam int K_READY = 0;
  localparam int K_SHOW  = 1;
  localparam int K_GAP   = 2;
  localparam int K_LVL   = 3;

  logic       clk_1khz = 1'b0;
  logic       rst = 1'b1;
  logic       req_success = 1'b0;
  logic       req_fail = 1'b0;
  logic       emergency = 1'b0;
  logic       lockout = 1'b0;
  logic [3:0] fb_state;
  logic       busy;
  logic [2:0] q_count;
  logic       ovf;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  bit         m_q[$];
  int         m_kind = K_READY;
  int         m_el = 0;
  logic [3:0] m_fb = 4'b0000;
  logic       m_ovf = 1'b0;

  logic       lv_em = 1'b0;
  logic       lv_lo = 1'b0;
  logic [3:0] prev_fb = 4'b0000;
  int         succ_plays = 0;
  int         fail_plays = 0;
  int         succ_cycles = 0;

  feedback_scheduler #(.SHOW_MS(SHOW), .GAP_MS(GAP)) dut (
    .clk_1khz    (clk_1khz),
    .rst         (rst),
    .req_success (req_success),
    .req_fail    (req_fail),
    .emergency   (emergency),
    .lockout     (lockout),
    .fb_state    (fb_state),
    .busy        (busy),
    .q_count     (q_count),
    .ovf         (ovf),
    .dbg_state   (dbg_state)
  );

  always #5 clk_1khz = ~clk_1khz;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_kind = K_READY;
    m_el = 0;
    m_fb = 4'b0000;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit e, input bit l);
    int  orig;
    bit  pop;
    bit  head;
    orig = m_q.size();
    pop = (m_kind == K_READY) && !(e || l) && (orig > 0);
    head = 1'b0;
    if (pop) head = m_q.pop_front();
    m_ovf = (s && f) || ((s || f) && orig == 4 && !pop);
    if ((s || f) && !(orig == 4 && !pop)) m_q.push_back(f);
    if (e || l) begin
      m_kind = K_LVL;
      m_fb = e ? 4'b1010 : 4'b1001;
    end else if (m_kind == K_LVL) begin
      m_kind = K_GAP;
      m_el = 1;
      m_fb = 4'b0000;
    end else if (m_kind == K_READY) begin
      if (pop) begin
        m_kind = K_SHOW;
        m_el = 1;
        m_fb = head ? 4'b1000 : 4'b0111;
      end else begin
        m_fb = 4'b0000;
      end
    end else if (m_kind == K_SHOW) begin
      if (m_el == SHOW) begin
        m_kind = K_GAP;
        m_el = 1;
        m_fb = 4'b0000;
      end else begin
        m_el++;
      end
    end else begin
      if (m_el == GAP) m_kind = K_READY;
      else m_el++;
    end
  endtask

  task automatic check_all();
    logic m_busy;
    m_busy = (m_kind != K_READY) || (m_q.size() != 0);
    chk("fb_state", fb_state, m_fb);
    chk("q_count", {1'b0, q_count}, 4'(m_q.size()));
    chk("ovf", {3'b0, ovf}, {3'b0, m_ovf});
    chk("busy", {3'b0, busy}, {3'b0, m_busy});
  endtask

  task automatic step(input bit s, input bit f);
    @(negedge clk_1khz);
    req_success = s;
    req_fail = f;
    emergency = lv_em;
    lockout = lv_lo;
    @(posedge clk_1khz);
    model_edge(s, f, lv_em, lv_lo);
    cyc++;
    #1;
    check_all();
    if (fb_state == 4'b0111 && prev_fb != 4'b0111) succ_plays++;
    if (fb_state == 4'b1000 && prev_fb != 4'b1000) fail_plays++;
    if (fb_state == 4'b0111) succ_cycles++;
    prev_fb = fb_state;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    // reset
    #12;
    chk("rst_fb", fb_state, 4'b0000);
    chk("rst_qc", {1'b0, q_count}, 4'd0);
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_ovf", {3'b0, ovf}, 4'd0);
    @(negedge clk_1khz);
    rst = 1'b0;
    model_reset();
    idle(2);

    // single success: hold length and count
    succ_plays = 0; succ_cycles = 0;
    step(1'b1, 1'b0);
    chk("lat_qc1", {1'b0, q_count}, 4'd1);
    step(1'b0, 1'b0);
    chk("lat_code", fb_state, 4'b0111);
    idle(SHOW + GAP + 3);
    chk("single_hold", 4'(succ_cycles), 4'(SHOW));
    chk("single_plays", 4'(succ_plays), 4'd1);

    // back-to-back fails
    fail_plays = 0;
    step(1'b0, 1'b1);
    idle(2);
    step(1'b0, 1'b1);
    idle(2 * (SHOW + GAP + 1) + 3);
    chk("b2b_plays", 4'(fail_plays), 4'd2);

    // overflow: six consecutive successes
    succ_plays = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      if (i == 5) chk("ovf_pulse", {3'b0, ovf}, 4'd1);
    end
    step(1'b0, 1'b0);
    chk("ovf_clear", {3'b0, ovf}, 4'd0);
    idle(6 * (SHOW + GAP + 1));
    chk("ovf_plays", 4'(succ_plays), 4'd5);

    // pre-emption mid-show with one queued event
    succ_plays = 0; fail_plays = 0;
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(3);
    lv_em = 1'b1;
    step(1'b0, 1'b0);
    chk("preempt_code", fb_state, 4'b1010);
    idle(3);
    lv_em = 1'b0;
    step(1'b0, 1'b0);
    chk("level_exit", fb_state, 4'b0000);
    idle(GAP + SHOW + GAP + 3);
    chk("preempt_succ", 4'(succ_plays), 4'd1);
    chk("preempt_fail", 4'(fail_plays), 4'd1);

    // level priority
    lv_lo = 1'b1;
    step(1'b0, 1'b0);
    chk("lockout_code", fb_state, 4'b1001);
    lv_em = 1'b1;
    step(1'b0, 1'b0);
    chk("em_wins", fb_state, 4'b1010);
    lv_em = 1'b0;
    step(1'b0, 1'b0);
    chk("back_lockout", fb_state, 4'b1001);
    lv_lo = 1'b0;
    idle(GAP + 2);

    // simultaneous requests
    fail_plays = 0; succ_plays = 0;
    step(1'b1, 1'b1);
    chk("simul_ovf", {3'b0, ovf}, 4'd1);
    chk("simul_qc", {1'b0, q_count}, 4'd1);
    idle(SHOW + GAP + 3);
    chk("simul_fail", 4'(fail_plays), 4'd1);
    chk("simul_succ", 4'(succ_plays), 4'd0);

    // asynchronous reset mid-show with a queued event
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    idle(2);
    @(negedge clk_1khz);
    #2 rst = 1'b1;
    #1;
    chk("arst_fb", fb_state, 4'b0000);
    chk("arst_qc", {1'b0, q_count}, 4'd0);
    chk("arst_busy", {3'b0, busy}, 4'd0);
    chk("arst_ovf", {3'b0, ovf}, 4'd0);
    @(posedge clk_1khz);
    @(negedge clk_1khz);
    rst = 1'b0;
    model_reset();
    prev_fb = 4'b0000;
    idle(SHOW + 2);

    // random traffic with occasional alarm episodes
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 79) == 0) lv_em = ~lv_em;
      if ($urandom_range(0, 89) == 0) lv_lo = ~lv_lo;
      step($urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    lv_em = 1'b0;
    lv_lo = 1'b0;
    idle(5 * (SHOW + GAP + 1) + GAP + 2);
    chk("drain_busy", {3'b0, busy}, 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
